// File: rtl/uart_deframe_fifo_if.sv
// Handshake bundle between the SIPO/receive controller and the deframer FIFO.
// Widths follow the same parameters as the deframer instance it connects to.
interface uart_deframe_fifo_if #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int PAR_EN    = 1,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 8
);
  localparam int FRAME_W = 1 + DATA_W + PAR_EN + STOP_BITS;
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  logic               frame_valid;
  logic [FRAME_W-1:0] frame_in;
  logic               par_mode;
  logic               out_ready;
  logic               clear_stats;
  logic               out_valid;
  logic [DATA_W-1:0]  data_out;
  logic [2:0]         err_out;
  logic [LVL_W-1:0]   fifo_level;
  logic               overflow_flag;
  logic [CNT_W-1:0]   parity_err_cnt;
  logic [CNT_W-1:0]   framing_err_cnt;
  logic [CNT_W-1:0]   overflow_cnt;

  modport master (
    output frame_valid, frame_in, par_mode, out_ready, clear_stats,
    input  out_valid, data_out, err_out, fifo_level, overflow_flag,
           parity_err_cnt, framing_err_cnt, overflow_cnt
  );

  modport slave (
    input  frame_valid, frame_in, par_mode, out_ready, clear_stats,
    output out_valid, data_out, err_out, fifo_level, overflow_flag,
           parity_err_cnt, framing_err_cnt, overflow_cnt
  );
endinterface

// File: rtl/uart_deframe_fifo.sv
// UART receive deframer: splits a parallel frame into data and error flags,
// queues the results in a small FIFO and keeps saturating error statistics.
module uart_deframe_fifo #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int PAR_EN    = 1,
  parameter int MSB_FIRST = 0,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 8
) (
  input logic              clock,
  input logic              reset,
  uart_deframe_fifo_if.slave bus
);
  localparam int FRAME_W = 1 + DATA_W + PAR_EN + STOP_BITS;
  localparam int AW      = $clog2(DEPTH);
  localparam int EW      = DATA_W + 3;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    if (en && (c != {CNT_W{1'b1}}))
      return c + CNT_W'(1);
    return c;
  endfunction

  // Stage p0: field extraction and error decode straight off the strobed frame
  logic              vld_p0;
  logic              start_p0;
  logic [DATA_W-1:0] line_p0;
  logic [DATA_W-1:0] data_p0;
  logic              par_bit_p0;
  logic              stop_ok_p0;
  logic              par_err_p0;
  logic              frm_err_p0;
  logic              brk_p0;

  assign vld_p0     = bus.frame_valid;
  assign start_p0   = bus.frame_in[FRAME_W-1];
  assign line_p0    = bus.frame_in[FRAME_W-2 -: DATA_W];
  assign par_bit_p0 = (PAR_EN != 0) ? bus.frame_in[STOP_BITS] : 1'b0;
  assign stop_ok_p0 = &bus.frame_in[STOP_BITS-1:0];
  assign brk_p0     = ~|bus.frame_in;
  assign frm_err_p0 = start_p0 | ~stop_ok_p0;
  assign par_err_p0 = (PAR_EN != 0) && ((^data_p0) ^ par_bit_p0 ^ bus.par_mode);

  // Line order is first-received at the top of line_p0; LSB-first lines reverse it.
  always_comb begin
    data_p0 = line_p0;
    if (MSB_FIRST == 0) begin
      for (int i = 0; i < DATA_W; i++)
        data_p0[i] = line_p0[DATA_W-1-i];
    end
  end

  logic [EW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    level;
  logic           full;
  logic           pop;
  logic           push_ok;
  logic           drop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign pop     = (level != '0) && bus.out_ready;
  assign push_ok = vld_p0 && (!full || pop);
  assign drop    = vld_p0 && full && !pop;

  // Stage p1: FIFO storage (data only, no reset) and control state
  always_ff @(posedge clock) begin
    if (push_ok)
      mem[wr_ptr] <= {data_p0, brk_p0, frm_err_p0, par_err_p0};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      level                <= '0;
      bus.overflow_flag    <= 1'b0;
      bus.parity_err_cnt   <= '0;
      bus.framing_err_cnt  <= '0;
      bus.overflow_cnt     <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (bus.clear_stats) begin
        bus.overflow_flag   <= 1'b0;
        bus.parity_err_cnt  <= '0;
        bus.framing_err_cnt <= '0;
        bus.overflow_cnt    <= '0;
      end else begin
        if (drop)
          bus.overflow_flag <= 1'b1;
        bus.parity_err_cnt  <= sat_inc(bus.parity_err_cnt,  push_ok && par_err_p0);
        bus.framing_err_cnt <= sat_inc(bus.framing_err_cnt, push_ok && frm_err_p0);
        bus.overflow_cnt    <= sat_inc(bus.overflow_cnt,    drop);
      end
    end
  end

  // Head view is forced to zero when empty so reset presents clean outputs.
  logic [EW-1:0] head;
  assign head          = (level != '0) ? mem[rd_ptr] : '0;
  assign bus.out_valid = (level != '0);
  assign bus.data_out  = head[EW-1:3];
  assign bus.err_out   = head[2:0];
  assign bus.fifo_level = level;
endmodule

// File: tb/tb_uart_deframe_fifo.sv
// Bench for uart_deframe_fifo: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_uart_deframe_fifo;
  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  uart_deframe_fifo_if #(.CNT_W(8)) bus ();
  uart_deframe_fifo_if #(.CNT_W(2)) bus2 ();

  uart_deframe_fifo #(.CNT_W(8)) dut  (.clock(clock), .reset(reset), .bus(bus));
  uart_deframe_fifo #(.CNT_W(2)) dut2 (.clock(clock), .reset(reset), .bus(bus2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { logic [7:0] d; logic [2:0] e; } ent_t;

  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic par, input logic stop);
    logic [7:0] line;
    for (int i = 0; i < 8; i++) line[7-i] = d[i];
    return {1'b0, line, par, stop};
  endfunction

  // Reference decode: walk the frame in received order (bit 10 first).
  function automatic ent_t decode(input logic [10:0] f, input logic pm);
    ent_t r;
    int ones;
    ones = 0;
    for (int k = 0; k < 8; k++) begin
      r.d[k] = f[9-k];
      if (f[9-k]) ones++;
    end
    if (f[1]) ones++;
    if (pm) ones++;
    r.e[0] = (ones % 2) != 0;
    r.e[1] = (f[10] == 1'b1) || (f[0] == 1'b0);
    r.e[2] = (f == 11'd0);
    return r;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    bus.frame_valid = 0; bus.frame_in = '0; bus.par_mode = 0; bus.out_ready = 0; bus.clear_stats = 0;
    bus2.frame_valid = 0; bus2.frame_in = '0; bus2.par_mode = 0; bus2.out_ready = 0; bus2.clear_stats = 0;
  endtask

  task automatic do_reset;
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.fifo_level !== 3'd0) begin miscompares++; $display("FAIL rst_level got %0d want 0", bus.fifo_level); end
    vectors++; if (bus.data_out !== 8'h00 || bus.err_out !== 3'b000) begin miscompares++; $display("FAIL rst_head got %h/%b want 00/000", bus.data_out, bus.err_out); end
    vectors++; if ({bus.overflow_flag, bus.parity_err_cnt, bus.framing_err_cnt, bus.overflow_cnt} !== 25'd0) begin miscompares++; $display("FAIL rst_stats got %b/%0d/%0d/%0d want 0", bus.overflow_flag, bus.parity_err_cnt, bus.framing_err_cnt, bus.overflow_cnt); end
  endtask

  task automatic test_basic;
    do_reset();
    bus.frame_valid = 1; bus.frame_in = 11'h295; bus.par_mode = 0;
    tick();
    bus.frame_valid = 0;
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b want 1", bus.out_valid); end
    vectors++; if (bus.data_out !== 8'hA5 || bus.err_out !== 3'b000) begin miscompares++; $display("FAIL basic_head got %h/%b want a5/000", bus.data_out, bus.err_out); end
    bus.out_ready = 1;
    tick();
    vectors++; if (bus.out_valid !== 1'b0 || bus.fifo_level !== 3'd0) begin miscompares++; $display("FAIL basic_pop got %b/%0d want 0/0", bus.out_valid, bus.fifo_level); end
  endtask

  task automatic test_parity;
    do_reset();
    bus.frame_valid = 1; bus.frame_in = 11'h295; bus.par_mode = 1;
    tick();
    vectors++; if (bus.err_out !== 3'b001 || bus.parity_err_cnt !== 8'd1) begin miscompares++; $display("FAIL par_odd got %b/%0d want 001/1", bus.err_out, bus.parity_err_cnt); end
    bus.frame_in = 11'h297; bus.out_ready = 1;
    tick();
    bus.frame_valid = 0;
    vectors++; if (bus.err_out !== 3'b000 || bus.data_out !== 8'hA5 || bus.parity_err_cnt !== 8'd1) begin miscompares++; $display("FAIL par_ok got %b/%h/%0d want 000/a5/1", bus.err_out, bus.data_out, bus.parity_err_cnt); end
  endtask

  task automatic test_framing;
    do_reset();
    bus.frame_valid = 1; bus.frame_in = 11'h294; bus.par_mode = 0;
    tick();
    vectors++; if (bus.err_out !== 3'b010 || bus.framing_err_cnt !== 8'd1) begin miscompares++; $display("FAIL frm_stop got %b/%0d want 010/1", bus.err_out, bus.framing_err_cnt); end
    bus.frame_in = 11'h000; bus.out_ready = 1;
    tick();
    bus.frame_valid = 0;
    vectors++; if (bus.data_out !== 8'h00 || bus.err_out !== 3'b110 || bus.framing_err_cnt !== 8'd2 || bus.parity_err_cnt !== 8'd0) begin miscompares++; $display("FAIL frm_break got %h/%b/%0d/%0d want 00/110/2/0", bus.data_out, bus.err_out, bus.framing_err_cnt, bus.parity_err_cnt); end
  endtask

  task automatic test_overflow;
    do_reset();
    bus.frame_valid = 1; bus.frame_in = 11'h295; bus.par_mode = 0;
    for (int i = 0; i < 5; i++) tick();
    vectors++; if (bus.fifo_level !== 3'd4 || bus.overflow_flag !== 1'b1 || bus.overflow_cnt !== 8'd1) begin miscompares++; $display("FAIL ovf_full got %0d/%b/%0d want 4/1/1", bus.fifo_level, bus.overflow_flag, bus.overflow_cnt); end
    bus.frame_in = make_frame(8'h3C, 1'b0, 1'b1); bus.out_ready = 1;
    tick();
    bus.frame_valid = 0;
    vectors++; if (bus.fifo_level !== 3'd4 || bus.overflow_cnt !== 8'd1) begin miscompares++; $display("FAIL ovf_pushpop got %0d/%0d want 4/1", bus.fifo_level, bus.overflow_cnt); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (bus.data_out !== 8'hA5) begin miscompares++; $display("FAIL ovf_drain%0d got %h want a5", i, bus.data_out); end
      tick();
    end
    vectors++; if (bus.data_out !== 8'h3C || bus.err_out !== 3'b000) begin miscompares++; $display("FAIL ovf_last got %h/%b want 3c/000", bus.data_out, bus.err_out); end
  endtask

  task automatic test_saturation;
    do_reset();
    bus2.out_ready = 1; bus2.frame_valid = 1; bus2.frame_in = 11'h295; bus2.par_mode = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      vectors++; if (bus2.parity_err_cnt !== 2'((i > 3) ? 3 : i)) begin miscompares++; $display("FAIL sat_%0d got %0d want %0d", i, bus2.parity_err_cnt, (i > 3) ? 3 : i); end
    end
    bus2.clear_stats = 1;
    tick();
    bus2.clear_stats = 0; bus2.frame_valid = 0;
    vectors++; if (bus2.parity_err_cnt !== 2'd0 || bus2.framing_err_cnt !== 2'd0) begin miscompares++; $display("FAIL sat_clear got %0d/%0d want 0/0", bus2.parity_err_cnt, bus2.framing_err_cnt); end
  endtask

  task automatic test_reset_midstream;
    do_reset();
    bus.frame_valid = 1; bus.frame_in = 11'h295; bus.par_mode = 1;
    for (int i = 0; i < 3; i++) tick();
    bus.frame_valid = 0;
    vectors++; if (bus.fifo_level !== 3'd3 || bus.parity_err_cnt !== 8'd3) begin miscompares++; $display("FAIL mid_pre got %0d/%0d want 3/3", bus.fifo_level, bus.parity_err_cnt); end
    #3 reset = 1;
    #1;
    vectors++; if (bus.out_valid !== 1'b0 || bus.fifo_level !== 3'd0 || bus.data_out !== 8'h00) begin miscompares++; $display("FAIL mid_async got %b/%0d/%h want 0/0/00", bus.out_valid, bus.fifo_level, bus.data_out); end
    vectors++; if (bus.parity_err_cnt !== 8'd0) begin miscompares++; $display("FAIL mid_cnt got %0d want 0", bus.parity_err_cnt); end
    #2 reset = 0;
    bus.frame_valid = 1; bus.frame_in = 11'h297; bus.par_mode = 1;
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_latency got %b want 0", bus.out_valid); end
    tick();
    bus.frame_valid = 0;
    vectors++; if (bus.out_valid !== 1'b1 || bus.data_out !== 8'hA5 || bus.err_out !== 3'b000 || bus.fifo_level !== 3'd1) begin miscompares++; $display("FAIL mid_first got %b/%h/%b/%0d want 1/a5/000/1", bus.out_valid, bus.data_out, bus.err_out, bus.fifo_level); end
  endtask

  task automatic test_random;
    ent_t q[$];
    ent_t m;
    int pc, fc, oc;
    bit ovf, pop, acc, drop;
    do_reset();
    pc = 0; fc = 0; oc = 0; ovf = 0;
    for (int n = 0; n < 800; n++) begin
      bus.frame_valid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0:       bus.frame_in = 11'd0;
        1, 2:    bus.frame_in = 11'($urandom);
        default: bus.frame_in = make_frame(8'($urandom), 1'($urandom), 1'b1);
      endcase
      bus.par_mode    = 1'($urandom);
      bus.out_ready   = ((n / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      bus.clear_stats = ($urandom_range(0, 31) == 0);
      m    = decode(bus.frame_in, bus.par_mode);
      pop  = (q.size() != 0) && bus.out_ready;
      acc  = bus.frame_valid && (q.size() < 4 || pop);
      drop = bus.frame_valid && !acc;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(m);
      if (bus.clear_stats) begin
        pc = 0; fc = 0; oc = 0; ovf = 0;
      end else begin
        if (acc && m.e[0] && pc < 255) pc++;
        if (acc && m.e[1] && fc < 255) fc++;
        if (drop) begin ovf = 1; if (oc < 255) oc++; end
      end
      tick();
      vectors++; if (bus.out_valid !== (q.size() != 0) || bus.fifo_level !== 3'(q.size())) begin miscompares++; $display("FAIL rnd_level n=%0d got %b/%0d want %0d", n, bus.out_valid, bus.fifo_level, q.size()); end
      if (q.size() != 0) begin
        vectors++; if (bus.data_out !== q[0].d || bus.err_out !== q[0].e) begin miscompares++; $display("FAIL rnd_head n=%0d got %h/%b want %h/%b", n, bus.data_out, bus.err_out, q[0].d, q[0].e); end
      end
      vectors++; if (bus.parity_err_cnt !== 8'(pc) || bus.framing_err_cnt !== 8'(fc) || bus.overflow_cnt !== 8'(oc) || bus.overflow_flag !== ovf) begin miscompares++; $display("FAIL rnd_stats n=%0d got %0d/%0d/%0d/%b want %0d/%0d/%0d/%b", n, bus.parity_err_cnt, bus.framing_err_cnt, bus.overflow_cnt, bus.overflow_flag, pc, fc, oc, ovf); end
    end
    idle();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    idle();
    reset = 1;
    #1;
    test_reset();
    tick();
    reset = 0;
    test_basic();
    test_parity();
    test_framing();
    test_overflow();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_deframe_fifo.md
Name: uart_deframe_fifo

Overview:
Parametrised, registered successor to the receive-side deframer. Accepts a complete parallel frame from the SIPO stage and splits out start, data, parity and stop bits. Data width, stop-bit count and bit order are compile-time options; parity mode is selectable at run time. Checks parity, framing and break conditions, buffers results in a DEPTH-entry FIFO with a valid/ready handshake, and keeps saturating error counters for the receive controller.

Parameters:
DATA_W, 8, data bits per frame (5..9)
STOP_BITS, 1, stop bits per frame (1 or 2)
PAR_EN, 1, parity bit present in frame (0/1)
MSB_FIRST, 0, 0 = line order LSB first, 1 = MSB first
DEPTH, 4, FIFO entries (power of 2, >= 2)
CNT_W, 8, error counter width
FRAME_W, 1+DATA_W+PAR_EN+STOP_BITS, derived; do not override

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
frame_valid  in  1  one-cycle strobe: frame_in holds a complete frame
frame_in  in  FRAME_W  frame, first-received bit at MSB
par_mode  in  1  0 = even, 1 = odd; sampled when frame_valid=1; ignored if PAR_EN=0
out_ready  in  1  consumer accepts the head entry
clear_stats  in  1  synchronous clear of counters and overflow_flag
out_valid  out  1  head entry available
data_out  out  DATA_W  head data, bit 0 = data LSB
err_out  out  3  head flags {break, framing, parity}
fifo_level  out  log2(DEPTH)+1  entries held
overflow_flag  out  1  sticky: frame dropped while FIFO full
parity_err_cnt  out  CNT_W  saturating count of parity errors
framing_err_cnt  out  CNT_W  saturating count of framing errors
overflow_cnt  out  CNT_W  saturating count of dropped frames

Behaviour:
- Reset (asynchronous, any time, including mid-burst): FIFO empty, out_valid=0, data_out=0, err_out=0, fifo_level=0, overflow_flag=0, all counters 0.
- Field extraction:
  - start = frame_in[FRAME_W-1].
  - The next DATA_W bits are data in line order. With MSB_FIRST=0, the first-received data bit is data bit 0.
  - Parity bit follows the data if PAR_EN=1.
  - Stop bits occupy the lowest STOP_BITS bits.
- Error flags:
  - parity: PAR_EN=1 and (XOR of data bits ^ parity bit ^ par_mode) != 0. Always 0 if PAR_EN=0.
  - framing: start != 0, or any stop bit != 1.
  - break: every bit of frame_in is 0. Break implies framing. Break does not force the parity flag.
- Push: on a clock edge with frame_valid=1, {data, flags} is written to the FIFO tail. Latency is 1 cycle: if the FIFO was empty, out_valid=1 and the outputs show the entry the cycle after the strobe.
- Pop: on an edge with out_valid=1 and out_ready=1, the head advances. data_out and err_out always reflect the current head. Their values are don't-care when out_valid=0.
- Simultaneous push and pop: both occur and the level is unchanged. When full, this push is accepted, not dropped.
- Overflow: push while full with no pop in the same cycle. The frame is dropped, FIFO contents are unchanged, overflow_flag is set, and overflow_cnt increments.
- Counters:
  - Each counter increments by 1 per accepted frame carrying its flag and saturates at 2^CNT_W-1; no wrap.
  - Dropped frames do not update parity_err_cnt or framing_err_cnt.
- clear_stats: zeroes the counters and overflow_flag on the next edge. If an increment occurs in the same cycle, clear wins. FIFO contents are untouched.
- Pointers: wrap modulo DEPTH. fifo_level ranges 0..DEPTH. Full means fifo_level==DEPTH.
- The block contains no combinational path from frame_in to any output.

Test Plan:
- Defaults, par_mode=0, frame_in=11'h295 strobed once -> next cycle out_valid=1, data_out=8'hA5, err_out=3'b000; out_ready=1 -> out_valid=0, fifo_level=0.
- par_mode=1 with 11'h295 -> err_out=3'b001, parity_err_cnt=1. Then 11'h297 -> err_out=3'b000, parity_err_cnt stays 1.
- 11'h294 (stop bit 0) -> err_out=3'b010, framing_err_cnt=1. 11'h000 with par_mode=0 -> data_out=8'h00, err_out=3'b110, framing_err_cnt=2.
- out_ready=0, 5 strobes of 11'h295 -> fifo_level=4, overflow_flag=1, overflow_cnt=1. Then push and pop in the same cycle while full -> accepted, level stays 4, overflow_cnt stays 1.
- CNT_W=2, 5 parity-error frames -> parity_err_cnt=3 (saturated). clear_stats together with a 6th error frame -> counter=0.
- Assert reset mid-stream with 3 entries queued -> out_valid=0, fifo_level=0, counters=0 immediately, without waiting for a clock edge. The first frame after release appears with 1-cycle latency.
